seg7_step_checker: RTL and testbench
====================================

# seg7_step_checker

Receiving-end monitor for the step-by-2 seven-segment counter display. Samples the active-low 7-bit segment bus, accepts a pattern only after it has held stable, and decodes it back to a BCD digit. It then checks that successive digits follow the (d+2) mod 10 sequence and reports the detected even/odd mode. It sits on the board-test side of the display, with its `seg` input tied to the counter's `led` output.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a pattern; legal range 2..15.
- ERR_W, 8: width of the saturating error counter.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- seg  in  [0:6]  segment bus, bit 0 = a … bit 6 = g, active-low (0 = lit).
- digit  out  4  last accepted digit, 0..9.
- digit_valid  out  1  one-cycle pulse per accepted legal digit.
- code_err  out  1  one-cycle pulse when an accepted pattern is not in the code table.
- seq_err  out  1  one-cycle pulse when an accepted digit breaks the +2 sequence.
- locked  out  1  high while a sequence reference is held.
- parity  out  1  0 = even sequence (0,2,4,6,8), 1 = odd (1,3,5,7,9); valid while locked.
- err_count  out  ERR_W  count of code_err + seq_err events; saturates at all-ones.

## Operation
- Code table, seg[0:6]:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001101
  - 8 = 0000000
  - 9 = 0000100
  - Blank = 1111111.
  - Any other pattern is illegal.
- Stability filter:
  - A run counter (4 bits) counts consecutive rising edges on which seg equals the previously sampled value.
  - Any change restarts the run at 1.
  - The counter saturates at STABLE_CYCLES.
- Acceptance: occurs exactly once per run, on the edge where the run reaches STABLE_CYCLES. A held pattern is never re-accepted.
- FSM states: UNLOCKED, LOCKED.
  - UNLOCKED, legal digit d accepted:
    - Set digit=d and pulse digit_valid.
    - Set parity=d[0] and expect=(d+2) mod 10.
    - Go to LOCKED.
  - LOCKED, d==expect: digit=d, pulse digit_valid, expect=(d+2) mod 10.
  - LOCKED, d!=expect:
    - digit=d; pulse digit_valid and seq_err; err_count+1.
    - Resync: parity=d[0], expect=(d+2) mod 10. Stay LOCKED.
  - Blank accepted (any state): go to UNLOCKED, no error, digit unchanged.
  - Illegal pattern accepted (any state): pulse code_err, err_count+1, go to UNLOCKED, digit unchanged.
- Wrap: expect after 8 is 0; expect after 9 is 1.
- err_count saturation: holds at 2^ERR_W-1. Pulses still fire.
- code_err and seq_err are never high in the same cycle.

## Timing
- Reset values:
  - digit=0, digit_valid=0, code_err=0, seq_err=0, locked=0, parity=0, err_count=0.
  - FSM=UNLOCKED; run counter=0.
- Edges with reset high never count toward a run. The first sample after reset release starts a run at 1.
- Reset asserted mid-run or while LOCKED: all state returns to reset values on that edge. The in-progress run is discarded.
- Latency: a pattern first sampled at edge N and held is accepted at edge N+STABLE_CYCLES-1. All outputs update on that edge and pulses last exactly one cycle.
- Glitch rejection: a pattern held fewer than STABLE_CYCLES edges produces no output activity.
- Minimum accepted rate: one digit per STABLE_CYCLES clocks.
- All outputs are registered; no combinational path from seg to any output.

## Test plan
- Reset, then present 0,2,4,6,8,0 (each held 4 cycles, STABLE_CYCLES=4):
  - digit_valid pulses 6 times, digits 0,2,4,6,8,0.
  - locked=1 after first digit, parity=0.
  - No errors; err_count=0.
- Present 7,9,1,3:
  - Wrap 9→1 accepted; parity=1; no seq_err.
- Present 2,4,8:
  - seq_err pulses with digit=8; err_count=1; locked stays 1.
  - Next digit 0 accepted with no error (resync).
- Present 4 for 3 cycles, then 6 for 4 cycles:
  - 4 is never accepted; only digit 6 pulses.
- Present 1110000 held 4 cycles:
  - code_err pulses; locked=0; digit unchanged; err_count increments.
  - Blank 1111111 then clears locked with no error.
- Saturation and reset, with ERR_W=2:
  - Force 5 errors; err_count stays 3.
  - Assert reset mid-run: all outputs 0 on next edge; pattern must re-hold 4 edges after release.

Source files
------------

// File: rtl/seg7_step_checker.sv
// Board-side monitor for the step-by-2 seven-segment counter: debounces the
// active-low segment bus, decodes it to BCD and checks the (d+2) mod 10 sequence.
module seg7_step_checker #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:6]       seg,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic             parity,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned RUN_W = 4;
  localparam logic [RUN_W-1:0] RUN_ACCEPT = RUN_W'(STABLE_CYCLES);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [0:6]       prev_seg;
  logic [RUN_W-1:0] run, run_nxt;
  logic             accept_c;
  logic [3:0]       exp_digit, exp_nxt;
  logic [3:0]       dec_digit;
  logic             dec_legal, dec_blank;
  logic [3:0]       digit_nxt;
  logic             valid_nxt, code_nxt, seq_nxt, parity_nxt, err_inc;
  logic [ERR_W-1:0] err_nxt;

  // Segment pattern to BCD digit; bit 0 of seg is segment a.
  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    case (seg)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001101: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      7'b1111111: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  // Run-length filter; a run of 0 means no sample since reset.
  always_comb begin
    run_nxt  = run;
    accept_c = 1'b0;
    if (run == '0 || seg != prev_seg) begin
      run_nxt = RUN_W'(1);
    end else if (run != RUN_ACCEPT) begin
      run_nxt  = run + RUN_W'(1);
      accept_c = (run == RUN_ACCEPT - RUN_W'(1));
    end
  end

  // Sequence FSM next state and registered-output next values.
  always_comb begin
    state_nxt  = state;
    digit_nxt  = digit;
    valid_nxt  = 1'b0;
    code_nxt   = 1'b0;
    seq_nxt    = 1'b0;
    parity_nxt = parity;
    exp_nxt    = exp_digit;
    err_inc    = 1'b0;
    if (accept_c) begin
      if (dec_legal) begin
        digit_nxt  = dec_digit;
        valid_nxt  = 1'b1;
        parity_nxt = dec_digit[0];
        exp_nxt    = (dec_digit >= 4'd8) ? dec_digit - 4'd8 : dec_digit + 4'd2;
        if (state == LOCKED && dec_digit != exp_digit) begin
          seq_nxt = 1'b1;
          err_inc = 1'b1;
        end
        state_nxt = LOCKED;
      end else if (dec_blank) begin
        state_nxt = UNLOCKED;
      end else begin
        code_nxt  = 1'b1;
        err_inc   = 1'b1;
        state_nxt = UNLOCKED;
      end
    end
    err_nxt = (err_inc && err_count != '1) ? err_count + ERR_W'(1) : err_count;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= UNLOCKED;
      prev_seg    <= '0;
      run         <= '0;
      exp_digit   <= 4'd0;
      digit       <= 4'd0;
      digit_valid <= 1'b0;
      code_err    <= 1'b0;
      seq_err     <= 1'b0;
      parity      <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      prev_seg    <= seg;
      run         <= run_nxt;
      exp_digit   <= exp_nxt;
      digit       <= digit_nxt;
      digit_valid <= valid_nxt;
      code_err    <= code_nxt;
      seq_err     <= seq_nxt;
      parity      <= parity_nxt;
      err_count   <= err_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_seg7_step_checker.sv
// Bench for seg7_step_checker: directed vector table, corner sequences and
// randomized patterns checked against a history-based reference model.
module tb_seg7_step_checker;

  localparam int S = 4;
  localparam logic [0:6] BLANK = 7'b1111111;
  localparam logic [0:6] ILL   = 7'b1110000;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:6] seg;

  logic [3:0] digit, digit2;
  logic       digit_valid, code_err, seq_err, locked, parity;
  logic       digit_valid2, code_err2, seq_err2, locked2, parity2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  seg7_step_checker #(.STABLE_CYCLES(S), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .seg(seg), .digit(digit), .digit_valid(digit_valid),
    .code_err(code_err), .seq_err(seq_err), .locked(locked), .parity(parity),
    .err_count(err_count));

  seg7_step_checker #(.STABLE_CYCLES(S), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .seg(seg), .digit(digit2), .digit_valid(digit_valid2),
    .code_err(code_err2), .seq_err(seq_err2), .locked(locked2), .parity(parity2),
    .err_count(err_count2));

  always #5 clk = ~clk;

  logic [0:6] code_tbl [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
                                7'b0000000, 7'b0000100};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: full sample history since reset, trimmed to S+1 entries.
  logic [0:6] hist [$];
  int m_digit, m_valid, m_code, m_seq, m_locked, m_parity, m_expect, m_err8, m_err2;

  function automatic int lookup(input logic [0:6] p);
    for (int i = 0; i < 10; i++) if (code_tbl[i] == p) return i;
    if (p == BLANK) return 10;
    return -1;
  endfunction

  task automatic bump_err();
    if (m_err8 < 255) m_err8++;
    if (m_err2 < 3) m_err2++;
  endtask

  task automatic model_edge(input logic r, input logic [0:6] s);
    int n;
    int d;
    bit acc;
    m_valid = 0; m_code = 0; m_seq = 0;
    if (r) begin
      hist.delete();
      m_digit = 0; m_locked = 0; m_parity = 0; m_expect = 0; m_err8 = 0; m_err2 = 0;
    end else begin
      hist.push_back(s);
      if (hist.size() > S + 1) hist.delete(0);
      n = hist.size();
      acc = (n >= S);
      if (acc) for (int k = n - S; k < n; k++) if (hist[k] != s) acc = 0;
      if (acc && n > S && hist[n-S-1] == s) acc = 0;
      if (acc) begin
        d = lookup(s);
        if (d >= 0 && d <= 9) begin
          if (m_locked != 0 && d != m_expect) begin
            m_seq = 1;
            bump_err();
          end
          m_digit = d; m_valid = 1; m_parity = d % 2;
          m_expect = (d + 2) % 10; m_locked = 1;
        end else if (d == 10) begin
          m_locked = 0;
        end else begin
          m_code = 1;
          bump_err();
          m_locked = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("digit", digit, m_digit);
    chk("digit_valid", digit_valid, m_valid);
    chk("code_err", code_err, m_code);
    chk("seq_err", seq_err, m_seq);
    chk("locked", locked, m_locked);
    if (m_locked != 0) chk("parity", parity, m_parity);
    chk("err_count", err_count, m_err8);
    chk("digit_w2", digit2, m_digit);
    chk("valid_w2", digit_valid2, m_valid);
    chk("code_err_w2", code_err2, m_code);
    chk("seq_err_w2", seq_err2, m_seq);
    chk("err_count_w2", err_count2, m_err2);
  endtask

  task automatic step(input logic r, input logic [0:6] s);
    reset = r;
    seg   = s;
    @(posedge clk);
    model_edge(r, s);
    #1;
    check_model();
  endtask

  task automatic hold(input logic [0:6] s, input int cyc);
    repeat (cyc) step(1'b0, s);
  endtask

  typedef struct {
    logic [0:6] pat;
    int cyc, dig, vld, se, ce, lk, par, err;
  } vec_t;

  function automatic vec_t mk(input logic [0:6] p, input int c, input int dg, input int v,
                              input int se, input int ce, input int lk, input int pr,
                              input int e);
    vec_t t;
    t.pat = p; t.cyc = c; t.dig = dg; t.vld = v; t.se = se; t.ce = ce;
    t.lk = lk; t.par = pr; t.err = e;
    return t;
  endfunction

  vec_t vecs [21];

  initial begin
    // pattern, hold, digit, valid, seq_err, code_err, locked, parity, err_count
    vecs[0]  = mk(code_tbl[0], 4, 0, 1, 0, 0, 1, 0, 0);
    vecs[1]  = mk(code_tbl[2], 4, 2, 1, 0, 0, 1, 0, 0);
    vecs[2]  = mk(code_tbl[4], 4, 4, 1, 0, 0, 1, 0, 0);
    vecs[3]  = mk(code_tbl[6], 4, 6, 1, 0, 0, 1, 0, 0);
    vecs[4]  = mk(code_tbl[8], 4, 8, 1, 0, 0, 1, 0, 0);
    vecs[5]  = mk(code_tbl[0], 4, 0, 1, 0, 0, 1, 0, 0);
    vecs[6]  = mk(BLANK,       4, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(code_tbl[7], 4, 7, 1, 0, 0, 1, 1, 0);
    vecs[8]  = mk(code_tbl[9], 4, 9, 1, 0, 0, 1, 1, 0);
    vecs[9]  = mk(code_tbl[1], 4, 1, 1, 0, 0, 1, 1, 0);
    vecs[10] = mk(code_tbl[3], 4, 3, 1, 0, 0, 1, 1, 0);
    vecs[11] = mk(BLANK,       4, 3, 0, 0, 0, 0, 1, 0);
    vecs[12] = mk(code_tbl[2], 4, 2, 1, 0, 0, 1, 0, 0);
    vecs[13] = mk(code_tbl[4], 4, 4, 1, 0, 0, 1, 0, 0);
    vecs[14] = mk(code_tbl[8], 4, 8, 1, 1, 0, 1, 0, 1);
    vecs[15] = mk(code_tbl[0], 4, 0, 1, 0, 0, 1, 0, 1);
    vecs[16] = mk(BLANK,       4, 0, 0, 0, 0, 0, 0, 1);
    vecs[17] = mk(code_tbl[4], 3, 0, 0, 0, 0, 0, 0, 1);
    vecs[18] = mk(code_tbl[6], 4, 6, 1, 0, 0, 1, 0, 1);
    vecs[19] = mk(ILL,         4, 6, 0, 0, 1, 0, 0, 2);
    vecs[20] = mk(BLANK,       4, 6, 0, 0, 0, 0, 0, 2);

    reset = 1'b1;
    seg   = BLANK;
    step(1'b1, BLANK);
    step(1'b1, BLANK);
    chk("rst_digit", digit, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_parity", parity, 0);
    chk("rst_err", err_count, 0);

    for (int i = 0; i < 21; i++) begin
      hold(vecs[i].pat, vecs[i].cyc);
      chk($sformatf("v%0d_digit", i), digit, vecs[i].dig);
      chk($sformatf("v%0d_valid", i), digit_valid, vecs[i].vld);
      chk($sformatf("v%0d_seq_err", i), seq_err, vecs[i].se);
      chk($sformatf("v%0d_code_err", i), code_err, vecs[i].ce);
      chk($sformatf("v%0d_locked", i), locked, vecs[i].lk);
      if (vecs[i].lk != 0) chk($sformatf("v%0d_parity", i), parity, vecs[i].par);
      chk($sformatf("v%0d_err", i), err_count, vecs[i].err);
    end

    // Five more errors: the 2-bit counter pins at 3 while pulses keep firing.
    for (int i = 0; i < 5; i++) begin
      hold(ILL, 4);
      chk("sat_code_err_pulse", code_err2, 1);
      hold(BLANK, 4);
    end
    chk("sat_err_w2", err_count2, 3);
    chk("sat_err_w8", err_count, 7);

    // Reset in the middle of a run discards it; the pattern must re-hold.
    hold(code_tbl[3], 4);
    chk("pre_rst_parity", parity, 1);
    hold(code_tbl[5], 2);
    step(1'b1, code_tbl[5]);
    chk("mid_rst_digit", digit, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_parity", parity, 0);
    chk("mid_rst_err", err_count2, 0);
    hold(code_tbl[5], 3);
    chk("post_rst_no_accept", digit_valid, 0);
    hold(code_tbl[5], 1);
    chk("post_rst_accept", digit_valid, 1);
    chk("post_rst_digit", digit, 5);

    // Randomized traffic: mostly in-sequence digits, with errors, blanks and resets.
    for (int i = 0; i < 400; i++) begin
      int sel;
      int cyc;
      logic [0:6] p;
      sel = int'($urandom_range(0, 19));
      cyc = int'($urandom_range(1, 6));
      if (sel < 10)       p = code_tbl[m_expect];
      else if (sel < 14)  p = code_tbl[$urandom_range(0, 9)];
      else if (sel < 16)  p = BLANK;
      else if (sel < 19)  p = 7'($urandom);
      else                p = BLANK;
      if (sel == 19) step(1'b1, p);
      hold(p, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
